// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC update scheduler and its frame shifter.
// Optional feature macro: SLEW_LIMIT_EN (adds the slew-limit helper).
package dac_sched_pkg;
  localparam int LEVEL_W      = 8;
  localparam int FRAME_LEN    = 16;
  localparam int DATA_LSB_BIT = 4;
  localparam int DATA_MSB_BIT = 11;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

`ifdef SLEW_LIMIT_EN
  // Move cur toward tgt by at most step; result clamped to the level range.
  function automatic logic [LEVEL_W-1:0] slew_limit(input logic [LEVEL_W-1:0] cur,
                                                    input logic [LEVEL_W-1:0] tgt,
                                                    input logic [LEVEL_W-1:0] step);
    logic signed [9:0] diff;  // value always fits in 9 signed bits
    logic signed [9:0] cur_s;
    logic signed [9:0] st;
    logic signed [9:0] nxt;
    logic [LEVEL_W-1:0] res;
    cur_s = $signed({2'b00, cur});
    st    = $signed({2'b00, step});
    diff  = $signed({2'b00, tgt}) - cur_s;
    if (diff > st)       nxt = cur_s + st;
    else if (diff < -st) nxt = cur_s - st;
    else                 nxt = $signed({2'b00, tgt});
    if (nxt < 0)                res = '0;
    else if (nxt > 10'sd255)    res = '1;
    else                        res = nxt[LEVEL_W-1:0];
    return res;
  endfunction
`endif
endpackage

// File: rtl/dac_frame_tx.sv
// Shifts one 16-bit DAC frame: 4 zero bits, 8 level bits MSB first, 4 zero bits.
// nSYNC/DIN are registered; last_bit flags the 16th bit clock.
module dac_frame_tx
  import dac_sched_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LEVEL_W-1:0] level,
  output logic               nSYNC,
  output logic               DIN,
  output logic               last_bit
);
  logic                 active;
  logic [3:0]           bit_cnt;
  logic [FRAME_LEN-1:0] sreg;
  logic [FRAME_LEN-1:0] frame;

  // Frame word with bit k of the frame at index FRAME_LEN-1-k.
  always_comb begin
    frame = '0;
    frame[FRAME_LEN-1-DATA_LSB_BIT -: LEVEL_W] = level;
  end

  // Bit sequencer: start presents bit 0 on the next clock, then one bit per clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      sreg    <= '0;
      nSYNC   <= 1'b1;
      DIN     <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      bit_cnt <= '0;
      sreg    <= frame << 1;
      nSYNC   <= 1'b0;
      DIN     <= frame[FRAME_LEN-1];
    end else if (active) begin
      if (bit_cnt == 4'(FRAME_LEN-1)) begin
        active <= 1'b0;
        nSYNC  <= 1'b1;
        DIN    <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        DIN     <= sreg[FRAME_LEN-1];
        sreg    <= sreg << 1;
      end
    end
  end

  assign last_bit = active && (bit_cnt == 4'(FRAME_LEN-1));
endmodule

// File: rtl/dac_update_scheduler.sv
// Shares the serial heater DAC between the control loop and the manual panel:
// captures newest level per source, picks the owner, rate-limits frame starts,
// and drives dac_frame_tx. Optional feature macro: SLEW_LIMIT_EN.
module dac_update_scheduler
  import dac_sched_pkg::*;
#(
  parameter int                 HOLDOFF     = 1000,
  parameter int                 MIN_GAP     = 2,
  parameter logic [LEVEL_W-1:0] RESET_LEVEL = '0
`ifdef SLEW_LIMIT_EN
  , parameter int               SLEW_STEP   = 4
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               loop_wr,
  input  logic [LEVEL_W-1:0] loop_level,
  input  logic               manual_wr,
  input  logic [LEVEL_W-1:0] manual_level,
  input  logic               manual_en,
  output logic               nSYNC,
  output logic               DIN,
  output logic               busy,
  output logic [LEVEL_W-1:0] current_level,
  output logic               update_done
);
  localparam int EFF = (HOLDOFF > FRAME_LEN + MIN_GAP) ? HOLDOFF : FRAME_LEN + MIN_GAP;
  localparam int HW  = ($clog2(EFF + 1) > 10) ? $clog2(EFF + 1) : 10;
  localparam int GW  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  // Counter is 1 in the clock after LOAD, so EFF-1 in IDLE lets the next LOAD land EFF clocks later.
  localparam logic [HW-1:0] HOLD_LAST = HW'(EFF - 1);

  state_t             state;
  logic [HW-1:0]      hold_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               rst_frame, sel_man;
  logic               loop_pend, man_pend;
  logic [LEVEL_W-1:0] loop_val, man_val, sent_level;
  logic [LEVEL_W-1:0] tgt, frame_level;
  logic               hold_done, sel_req, reached, consume, last_bit;

  assign hold_done = (hold_cnt >= HOLD_LAST);
  // A same-cycle write counts as pending so an idle write reaches LOAD on the next clock.
  assign sel_req   = manual_en ? (man_pend | manual_wr) : (loop_pend | loop_wr);
  assign tgt       = sel_man ? man_val : loop_val;

`ifdef SLEW_LIMIT_EN
  assign frame_level = rst_frame ? RESET_LEVEL
                                 : slew_limit(current_level, tgt, LEVEL_W'(SLEW_STEP));
`else
  assign frame_level = rst_frame ? RESET_LEVEL : tgt;
`endif

  // A partially ramped target stays pending so later frames keep moving toward it.
  assign reached = (frame_level == tgt);
  assign consume = (state == LOAD) && !rst_frame && reached;

  // Per-source capture: newest write wins and beats a same-cycle consume.
  always_ff @(posedge clock) begin
    if (reset) begin
      loop_pend <= 1'b0;
      man_pend  <= 1'b0;
      loop_val  <= '0;
      man_val   <= '0;
    end else begin
      if (loop_wr) begin
        loop_val  <= loop_level;
        loop_pend <= 1'b1;
      end else if (consume && !sel_man) begin
        loop_pend <= 1'b0;
      end
      if (manual_wr) begin
        man_val  <= manual_level;
        man_pend <= 1'b1;
      end else if (consume && sel_man) begin
        man_pend <= 1'b0;
      end
    end
  end

  // Holdoff timer restarts at each frame start and saturates once expired.
  always_ff @(posedge clock) begin
    if (reset)               hold_cnt <= '0;
    else if (state == LOAD)  hold_cnt <= HW'(1);
    else if (!hold_done)     hold_cnt <= hold_cnt + HW'(1);
  end

  // Frame sequencer; reset lands in LOAD so the reset level is always sent.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= LOAD;
      busy          <= 1'b0;
      current_level <= '0;
      sent_level    <= '0;
      rst_frame     <= 1'b1;
      sel_man       <= 1'b0;
      gap_cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (sel_req && hold_done) begin
          state   <= LOAD;
          sel_man <= manual_en;
        end
        LOAD: begin
          state      <= SHIFT;
          busy       <= 1'b1;
          sent_level <= frame_level;
          rst_frame  <= 1'b0;
        end
        SHIFT: if (last_bit) begin
          state         <= GAP;
          current_level <= sent_level;
          gap_cnt       <= '0;
        end
        GAP: begin
          if (gap_cnt == GW'(MIN_GAP - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign update_done = last_bit;

  dac_frame_tx u_tx (
    .clock    (clock),
    .reset    (reset),
    .start    (state == LOAD),
    .level    (frame_level),
    .nSYNC    (nSYNC),
    .DIN      (DIN),
    .last_bit (last_bit)
  );
endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler; a negedge monitor decodes DAC frames
// and checks them against levels queued by the stimulus sequence.
module tb_dac_update_scheduler;
  localparam int HOLDOFF = 40;
  localparam int MIN_GAP = 2;
  localparam int EFF     = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       loop_wr = 1'b0, manual_wr = 1'b0, manual_en = 1'b0;
  logic [7:0] loop_level = '0, manual_level = '0;
  logic       nSYNC, DIN, busy, update_done;
  logic [7:0] current_level;

  dac_update_scheduler #(.HOLDOFF(HOLDOFF), .MIN_GAP(MIN_GAP), .RESET_LEVEL(8'h00)) dut (
    .clock(clock), .reset(reset),
    .loop_wr(loop_wr), .loop_level(loop_level),
    .manual_wr(manual_wr), .manual_level(manual_level), .manual_en(manual_en),
    .nSYNC(nSYNC), .DIN(DIN), .busy(busy),
    .current_level(current_level), .update_done(update_done)
  );

  always #5 clock = ~clock;

  int         ncmp = 0, nfail = 0;
  int         cyc = 0;
  int         frames_done = 0;
  int         prev_start = 0, last_start = 0;
  logic [7:0] exp_q[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: sample DIN mid-bit, check framing, score the level.
  int          mk = 0;
  logic        in_fr = 1'b0, post = 1'b0;
  logic [15:0] fbits = '0;
  logic [7:0]  e;
  always @(negedge clock) begin
    if (reset) begin
      in_fr = 1'b0; post = 1'b0; mk = 0;
    end else if (post) begin
      post = 1'b0;
      chk("nsync_len", nSYNC, 1);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("frame_bits", fbits, {4'h0, e, 4'h0});
        chk("current_level", current_level, e);
      end
      frames_done++;
    end else begin
      if (!in_fr && nSYNC === 1'b0) begin
        in_fr = 1'b1; mk = 0;
        prev_start = last_start; last_start = cyc;
        chk("busy_in_frame", busy, 1);
      end
      if (in_fr) begin
        if (nSYNC !== 1'b0) begin
          chk("nsync_low", nSYNC, 0);
          in_fr = 1'b0;
        end else begin
          fbits[15-mk] = DIN;
          chk("update_done", update_done, (mk == 15));
          mk++;
          if (mk == 16) begin in_fr = 1'b0; post = 1'b1; end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clock); n++;
    end
    #1;
    chk("frame_timeout", frames_done >= target, 1);
  endtask

  initial begin
    int nf;
    // Reset state, then the automatic RESET_LEVEL frame
    step(3);
    chk("rst_nsync", nSYNC, 1);
    chk("rst_din", DIN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    chk("rst_level", current_level, 0);
    exp_q.push_back(8'h00);
    reset = 1'b0;
    wait_frames(1, 200);

    // Idle write 0xA5 with holdoff expired: LOAD next clock, nSYNC falls the clock after
    step(EFF);
    loop_level = 8'hA5; loop_wr = 1'b1; exp_q.push_back(8'hA5);
    step(1);
    loop_wr = 1'b0;
    chk("lat_nsync_high", nSYNC, 1);
    step(1);
    chk("lat_nsync_fall", nSYNC, 0);
    wait_frames(2, 200);

    // Coalescing: three writes during one frame, only the newest is sent after holdoff
    step(EFF);
    loop_level = 8'h55; loop_wr = 1'b1; exp_q.push_back(8'h55);
    step(1);
    loop_wr = 1'b0;
    step(2);
    loop_level = 8'h10; loop_wr = 1'b1; step(1);
    loop_level = 8'h20; step(1);
    loop_level = 8'h30; step(1);
    loop_wr = 1'b0; exp_q.push_back(8'h30);
    wait_frames(4, 300);
    chk("holdoff_spacing", (last_start - prev_start) >= EFF, 1);

    // Manual ownership: manual sent first, held loop value follows once released
    step(EFF);
    manual_en = 1'b1;
    loop_level = 8'h40; loop_wr = 1'b1;
    manual_level = 8'h80; manual_wr = 1'b1;
    exp_q.push_back(8'h80);
    step(1);
    loop_wr = 1'b0; manual_wr = 1'b0;
    wait_frames(5, 300);
    step(EFF);
    chk("loop_held", frames_done, 5);
    exp_q.push_back(8'h40);
    manual_en = 1'b0;
    wait_frames(6, 300);

    // Reset during SHIFT bit 7: frame aborted, outputs reset, then 0x00 frame
    step(EFF);
    loop_level = 8'h77; loop_wr = 1'b1;
    step(1);
    loop_wr = 1'b0;
    nf = 0;
    while (nSYNC !== 1'b0 && nf < 50) begin @(negedge clock); nf++; end
    chk("abort_frame_seen", nSYNC, 0);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_nsync", nSYNC, 1);
    chk("mid_rst_din", DIN, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", update_done, 0);
    chk("mid_rst_level", current_level, 0);
    exp_q.push_back(8'h00);
    step(1);
    reset = 1'b0;
    wait_frames(7, 300);

    // Target 0x0A from level 0x00: ramped when slew limiting is built in
    step(EFF);
    loop_level = 8'h0A; loop_wr = 1'b1;
`ifdef SLEW_LIMIT_EN
    exp_q.push_back(8'h04); exp_q.push_back(8'h08); exp_q.push_back(8'h0A);
    nf = 10;
`else
    exp_q.push_back(8'h0A);
    nf = 8;
`endif
    step(1);
    loop_wr = 1'b0;
    wait_frames(nf, 600);
    step(3 * EFF);
    chk("idle_after", frames_done, nf);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
